nf2_dma_txfifo_dispatch: RTL and testbench
==========================================

NF2_DMA_TXFIFO_DISPATCH -- requirements
Module: nf2_dma_txfifo_dispatch

Interface
REQ-001 SHALL have parameter DMA_DATA_WIDTH, default 32, DMA data word width.
REQ-002 SHALL have parameter NUM_CPU_QUEUES, default 4, number of CPU queues (1..16).
REQ-003 SHALL have port cpci_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port cpci_reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port txfifo_empty, input, 1, DMA tx FIFO empty; the FIFO is first-word-fall-through.
REQ-006 SHALL have port txfifo_rd_data, input, DMA_DATA_WIDTH+4, the head word {fmt, eop/dir, bytecnt[1:0], data}.
REQ-007 SHALL have port txfifo_rd_en, output, 1, pops the head word.
REQ-008 SHALL have port rxfifo_full, input, 1, DMA rx FIFO full.
REQ-009 SHALL have port rxfifo_wr, output, 1, rx FIFO write strobe.
REQ-010 SHALL have port rxfifo_wr_data, output, DMA_DATA_WIDTH+3, rx FIFO word {eop, bytecnt[1:0], data}.
REQ-011 SHALL have port cpu_q_tx_wr, output, NUM_CPU_QUEUES, one-hot per-queue write.
REQ-012 SHALL have port cpu_q_tx_data, output, DMA_DATA_WIDTH+3, {eop, bytecnt, data}, shared by all queues.
REQ-013 SHALL have port cpu_q_tx_full, input, NUM_CPU_QUEUES, per-queue full.
REQ-014 SHALL have port cpu_q_rx_empty, input, NUM_CPU_QUEUES, per-queue empty; the queues are FWFT.
REQ-015 SHALL have port cpu_q_rx_rd_en, output, NUM_CPU_QUEUES, one-hot per-queue pop.
REQ-016 SHALL have port cpu_q_rx_data, input, NUM_CPU_QUEUES*(DMA_DATA_WIDTH+3), per-queue head words {eop, bytecnt, data}; queue i occupies slice i.
REQ-017 SHALL have port err_bad_qid, output, 1, one-cycle pulse.
REQ-018 SHALL have port err_protocol, output, 1, one-cycle pulse.
REQ-019 SHALL have port tx_pkt_cnt, output, 16, count of packets delivered to CPU queues.
REQ-020 SHALL have port rx_pkt_cnt, output, 16, count of packets delivered to the rx FIFO.

Function
REQ-021 SHALL decode txfifo words as follows:
- bit W+3 = 1: request word; bit W+2 = direction (0 tx, 1 rx); data[3:0] = qid.
- bit W+3 = 0: data word; bit W+2 = EOP; bytecnt 00 means 4 bytes, 01..11 means 1..3 bytes.
REQ-022 SHALL implement the FSM states IDLE, TX_DATA, RX_DATA and DROP, plus a 4-bit qid register.
REQ-023 In IDLE, when !txfifo_empty, SHALL pop one word in that cycle and act on it:
- tx request with qid < NUM_CPU_QUEUES: latch qid, go to TX_DATA.
- rx request with qid < NUM_CPU_QUEUES: latch qid, go to RX_DATA.
REQ-024 In IDLE, a request with qid >= NUM_CPU_QUEUES SHALL:
- pulse err_bad_qid;
- for tx, go to DROP;
- for rx, wait until !rxfifo_full, then write one filler word {eop=1, bytecnt=00, data=0} to the rx FIFO and stay in IDLE; rx_pkt_cnt is not incremented.
REQ-025 In IDLE, a data word SHALL be popped and discarded, pulse err_protocol, and leave the state at IDLE.
REQ-026 TX_DATA SHALL transfer a word only when !txfifo_empty && !cpu_q_tx_full[qid] && head is a data word. In that cycle:
- txfifo_rd_en = 1;
- cpu_q_tx_wr[qid] = 1;
- cpu_q_tx_data = head bits [W+2:0], combinational, zero latency.
REQ-027 In TX_DATA, an EOP word SHALL increment tx_pkt_cnt and return the FSM to IDLE on the same clock edge.
REQ-028 In TX_DATA, a request word at the head SHALL NOT be popped; the block SHALL pulse err_protocol and go to IDLE, which then services that request.
REQ-029 RX_DATA SHALL transfer a word only when !cpu_q_rx_empty[qid] && !rxfifo_full. In that cycle:
- cpu_q_rx_rd_en[qid] = 1;
- rxfifo_wr = 1;
- rxfifo_wr_data = slice qid of cpu_q_rx_data.
On EOP, rx_pkt_cnt increments and the FSM goes to IDLE. txfifo SHALL NOT be popped in RX_DATA.
REQ-030 DROP SHALL pop data words while !txfifo_empty, ignoring the queue full flags, and go to IDLE after the EOP word. A request word at the head SHALL go to IDLE without being popped.
REQ-031 Throughput SHALL be one word per clock in TX_DATA, RX_DATA and DROP. No bubble is required between packets beyond the one IDLE cycle taken by the request word.
REQ-032 All strobes (txfifo_rd_en, rxfifo_wr, cpu_q_tx_wr, cpu_q_rx_rd_en) SHALL be combinational from state, qid and the current flags, so that no overflow or underflow is possible.
REQ-033 cpu_q_tx_wr and cpu_q_rx_rd_en SHALL be zero at every bit other than qid. Unused data outputs SHALL be 0 when their strobe is 0.
REQ-034 tx_pkt_cnt and rx_pkt_cnt SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-035 Asserting cpci_reset_n low SHALL immediately force:
- state = IDLE, qid = 0, both counters = 0, err_bad_qid = err_protocol = 0;
- all strobes deasserted.
REQ-036 A packet in progress when reset asserts SHALL be abandoned. Its remaining txfifo data words are handled per REQ-025 after reset.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- tx req qid=2, then data words with bytecnt 00,00,10 EOP -> cpu_q_tx_wr = 4'b0100 on 3 cycles with data passed unchanged; tx_pkt_cnt = 1.
- tx req qid=1 with cpu_q_tx_full[1] toggling every other cycle -> no write while full; no word lost or duplicated; 5-word packet complete.
- rx req qid=3, queue 3 holds a 3-word packet, rxfifo_full held high 2 cycles mid-packet -> 3 rxfifo writes in order, last with eop=1; rx_pkt_cnt = 1.
- tx req qid=7 (NUM=4) followed by a 2-word packet -> err_bad_qid pulse; 2 words popped; no cpu_q_tx_wr. rx req qid=9 -> one filler word written.
- tx req qid=0, 1 data word without EOP, then rx req qid=0 -> err_protocol pulse; rx request then serviced.
- reset asserted mid tx packet -> outputs 0 asynchronously; leftover data words each pulse err_protocol; the next request is serviced normally.

Source files
------------

// File: rtl/nf2_dma_txfifo_dispatch_if.sv
// Bus bundle linking the DMA tx/rx FIFOs and the CPU queues to the dispatcher.
// The master side is the dispatcher. The slave side is the FIFO and queue fabric around it.
interface nf2_dma_txfifo_dispatch_if #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int NUM_CPU_QUEUES = 4
);
    logic                                         txfifo_empty;
    logic [DMA_DATA_WIDTH+3:0]                    txfifo_rd_data;
    logic                                         txfifo_rd_en;
    logic                                         rxfifo_full;
    logic                                         rxfifo_wr;
    logic [DMA_DATA_WIDTH+2:0]                    rxfifo_wr_data;
    logic [NUM_CPU_QUEUES-1:0]                    cpu_q_tx_wr;
    logic [DMA_DATA_WIDTH+2:0]                    cpu_q_tx_data;
    logic [NUM_CPU_QUEUES-1:0]                    cpu_q_tx_full;
    logic [NUM_CPU_QUEUES-1:0]                    cpu_q_rx_empty;
    logic [NUM_CPU_QUEUES-1:0]                    cpu_q_rx_rd_en;
    logic [NUM_CPU_QUEUES*(DMA_DATA_WIDTH+3)-1:0] cpu_q_rx_data;
    logic                                         err_bad_qid;
    logic                                         err_protocol;
    logic [15:0]                                  tx_pkt_cnt;
    logic [15:0]                                  rx_pkt_cnt;

    modport master (
        input  txfifo_empty, txfifo_rd_data, rxfifo_full,
               cpu_q_tx_full, cpu_q_rx_empty, cpu_q_rx_data,
        output txfifo_rd_en, rxfifo_wr, rxfifo_wr_data,
               cpu_q_tx_wr, cpu_q_tx_data, cpu_q_rx_rd_en,
               err_bad_qid, err_protocol, tx_pkt_cnt, rx_pkt_cnt
    );

    modport slave (
        output txfifo_empty, txfifo_rd_data, rxfifo_full,
               cpu_q_tx_full, cpu_q_rx_empty, cpu_q_rx_data,
        input  txfifo_rd_en, rxfifo_wr, rxfifo_wr_data,
               cpu_q_tx_wr, cpu_q_tx_data, cpu_q_rx_rd_en,
               err_bad_qid, err_protocol, tx_pkt_cnt, rx_pkt_cnt
    );
endinterface

// File: rtl/nf2_dma_txfifo_dispatch.sv
// DMA tx FIFO dispatcher. It reads request and data words from the DMA tx FIFO.
// Tx packets are steered into one CPU queue. Rx requests pull a packet from a CPU
// queue into the DMA rx FIFO. All strobes are combinational from the registered
// state and the live flags, so a FIFO can never overflow or underflow.
module nf2_dma_txfifo_dispatch #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int NUM_CPU_QUEUES = 4
) (
    input  logic                             cpci_clk,
    input  logic                             cpci_reset_n,
    nf2_dma_txfifo_dispatch_if.master        bus
);
    localparam int W  = DMA_DATA_WIDTH;
    localparam int N  = NUM_CPU_QUEUES;
    localparam int QW = W + 3;

    typedef enum logic [1:0] {
        IDLE,
        TX_DATA,
        RX_DATA,
        DROP
    } state_t;

    state_t      state;
    logic [3:0]  qid;
    logic        fill_pend;
    logic        err_bad_qid_r;
    logic        err_protocol_r;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;

    logic        head_is_req;
    logic        head_flag;
    logic [3:0]  head_qid;
    logic        head_qid_ok;

    assign head_is_req = bus.txfifo_rd_data[W+3];
    assign head_flag   = bus.txfifo_rd_data[W+2];
    assign head_qid    = bus.txfifo_rd_data[3:0];
    assign head_qid_ok = ({1'b0, head_qid} < 5'(N));

    logic [N-1:0]  qsel;
    logic          sel_tx_full;
    logic          sel_rx_empty;
    logic [QW-1:0] sel_rx_data;

    // Decode the latched qid into a one-hot select and pick that queue's flags and head word
    always_comb begin
        qsel        = '0;
        sel_rx_data = '0;
        for (int i = 0; i < N; i++) begin
            qsel[i]     = (qid == 4'(i));
            sel_rx_data = sel_rx_data | ({QW{qsel[i]}} & bus.cpu_q_rx_data[i*QW +: QW]);
        end
        sel_tx_full  = |(bus.cpu_q_tx_full & qsel);
        sel_rx_empty = |(bus.cpu_q_rx_empty & qsel);
    end

    logic idle_pop;
    logic fill_go;
    logic tx_go;
    logic rx_go;
    logic drop_go;

    // Work out which transfer may happen this cycle; reset holds every strobe low
    always_comb begin
        idle_pop = 1'b0;
        fill_go  = 1'b0;
        tx_go    = 1'b0;
        rx_go    = 1'b0;
        drop_go  = 1'b0;
        if (cpci_reset_n) begin
            case (state)
                IDLE: begin
                    if (fill_pend) begin
                        fill_go = !bus.rxfifo_full;
                    end else begin
                        idle_pop = !bus.txfifo_empty;
                    end
                end
                TX_DATA: tx_go   = !bus.txfifo_empty && !sel_tx_full && !head_is_req;
                RX_DATA: rx_go   = !sel_rx_empty && !bus.rxfifo_full;
                DROP:    drop_go = !bus.txfifo_empty && !head_is_req;
                default: ;
            endcase
        end
    end

    assign bus.txfifo_rd_en   = idle_pop | tx_go | drop_go;
    assign bus.cpu_q_tx_wr    = tx_go ? qsel : '0;
    assign bus.cpu_q_tx_data  = tx_go ? bus.txfifo_rd_data[W+2:0] : '0;
    assign bus.cpu_q_rx_rd_en = rx_go ? qsel : '0;
    assign bus.rxfifo_wr      = rx_go | fill_go;
    assign bus.rxfifo_wr_data = rx_go   ? sel_rx_data :
                                fill_go ? {1'b1, {(QW-1){1'b0}}} : '0;
    assign bus.err_bad_qid    = err_bad_qid_r;
    assign bus.err_protocol   = err_protocol_r;
    assign bus.tx_pkt_cnt     = tx_cnt;
    assign bus.rx_pkt_cnt     = rx_cnt;

    // Dispatcher FSM with its qid, filler flag, error pulses and packet counters
    always_ff @(posedge cpci_clk or negedge cpci_reset_n) begin
        if (!cpci_reset_n) begin
            state          <= IDLE;
            qid            <= 4'd0;
            fill_pend      <= 1'b0;
            err_bad_qid_r  <= 1'b0;
            err_protocol_r <= 1'b0;
            tx_cnt         <= 16'd0;
            rx_cnt         <= 16'd0;
        end else begin
            err_bad_qid_r  <= 1'b0;
            err_protocol_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_go) begin
                        fill_pend <= 1'b0;
                    end else if (idle_pop) begin
                        if (!head_is_req) begin
                            err_protocol_r <= 1'b1;
                        end else if (!head_qid_ok) begin
                            err_bad_qid_r <= 1'b1;
                            if (head_flag) begin
                                fill_pend <= 1'b1;
                            end else begin
                                state <= DROP;
                            end
                        end else begin
                            qid   <= head_qid;
                            state <= head_flag ? RX_DATA : TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (!bus.txfifo_empty && head_is_req) begin
                        err_protocol_r <= 1'b1;
                        state          <= IDLE;
                    end else if (tx_go && head_flag) begin
                        tx_cnt <= tx_cnt + 16'd1;
                        state  <= IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_go && sel_rx_data[QW-1]) begin
                        rx_cnt <= rx_cnt + 16'd1;
                        state  <= IDLE;
                    end
                end
                DROP: begin
                    if (!bus.txfifo_empty && head_is_req) begin
                        state <= IDLE;
                    end else if (drop_go && head_flag) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nf2_dma_txfifo_dispatch.sv
// Directed bench for nf2_dma_txfifo_dispatch. The FIFOs and queues are modelled as
// SV queues. Each scenario states which words must come out where, and a negedge
// monitor checks every strobe and data word against that expected stream.
module tb_nf2_dma_txfifo_dispatch;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int QW = W + 3;

    logic cpci_clk     = 1'b0;
    logic cpci_reset_n = 1'b0;

    // Free-running 100 MHz clock
    always #5 cpci_clk = ~cpci_clk;

    nf2_dma_txfifo_dispatch_if #(.DMA_DATA_WIDTH(W), .NUM_CPU_QUEUES(N)) bus ();

    nf2_dma_txfifo_dispatch #(.DMA_DATA_WIDTH(W), .NUM_CPU_QUEUES(N)) dut (
        .cpci_clk    (cpci_clk),
        .cpci_reset_n(cpci_reset_n),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [35:0] txq [$];
    logic [34:0] rxq [N][$];
    logic [38:0] exp_tx [$];
    logic [39:0] exp_rx [$];
    logic [N-1:0] tx_full_v = '0;
    logic         rx_full_v = 1'b0;

    int mdl_tx    = 0;
    int mdl_rx    = 0;
    int n_bad_qid = 0;
    int n_proto   = 0;
    int n_txwr    = 0;
    int n_rxwr    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [35:0] req(input logic dir, input logic [3:0] q);
        return {1'b1, dir, 30'd0, q};
    endfunction

    function automatic logic [35:0] dw(input logic eop, input logic [1:0] bc, input logic [31:0] d);
        return {1'b0, eop, bc, d};
    endfunction

    task automatic addTx(input logic [35:0] w, input int q);
        txq.push_back(w);
        if (q >= 0) exp_tx.push_back({4'(q), w[34:0]});
    endtask

    task automatic addRx(input int q, input logic [34:0] w);
        rxq[q].push_back(w);
        exp_rx.push_back({1'b0, 4'(q), w});
    endtask

    task automatic addFiller();
        exp_rx.push_back({1'b1, 4'd0, 35'h4_0000_0000});
    endtask

    function automatic bit allDone();
        bit d;
        d = (txq.size() == 0) && (exp_tx.size() == 0) && (exp_rx.size() == 0);
        for (int i = 0; i < N; i++) d = d && (rxq[i].size() == 0);
        return d;
    endfunction

    task automatic updateInputs();
        bus.txfifo_empty   = (txq.size() == 0);
        bus.txfifo_rd_data = (txq.size() == 0) ? 36'd0 : txq[0];
        bus.rxfifo_full    = rx_full_v;
        bus.cpu_q_tx_full  = tx_full_v;
        for (int i = 0; i < N; i++) begin
            bus.cpu_q_rx_empty[i]          = (rxq[i].size() == 0);
            bus.cpu_q_rx_data[i*QW +: QW]  = (rxq[i].size() == 0) ? 35'd0 : rxq[i][0];
        end
    endtask

    task automatic applyStimulus(input int n);
        logic         s_rd;
        logic [N-1:0] s_rx;
        for (int k = 0; k < n; k++) begin
            updateInputs();
            @(negedge cpci_clk);
            s_rd = bus.txfifo_rd_en;
            s_rx = bus.cpu_q_rx_rd_en;
            @(posedge cpci_clk);
            #1;
            if (cpci_reset_n) begin
                if (s_rd && txq.size() > 0) void'(txq.pop_front());
                for (int i = 0; i < N; i++)
                    if (s_rx[i] && rxq[i].size() > 0) void'(rxq[i].pop_front());
            end
            updateInputs();
        end
    endtask

    task automatic runUntilDone(input string name, input int budget);
        int n = 0;
        while (!allDone() && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput({name, "_done"}, 64'(allDone()), 64'd1);
        applyStimulus(2);
    endtask

    logic [38:0]  et;
    logic [39:0]  er;
    logic [N-1:0] oh;

    // Monitor: every cycle, compare strobes, data and counters against the expected streams
    always @(negedge cpci_clk) begin
        if (!cpci_reset_n) begin
            checkOutput("reset_quiet",
                {bus.txfifo_rd_en, bus.cpu_q_tx_wr, bus.cpu_q_rx_rd_en, bus.rxfifo_wr,
                 bus.err_bad_qid, bus.err_protocol, bus.tx_pkt_cnt, bus.rx_pkt_cnt}, 64'd0);
            mdl_tx = 0;
            mdl_rx = 0;
        end else begin
            checkOutput("tx_pkt_cnt", bus.tx_pkt_cnt, 64'(16'(mdl_tx)));
            checkOutput("rx_pkt_cnt", bus.rx_pkt_cnt, 64'(16'(mdl_rx)));
            if (bus.err_bad_qid)  n_bad_qid++;
            if (bus.err_protocol) n_proto++;
            if (bus.txfifo_rd_en) checkOutput("txfifo_underflow", bus.txfifo_empty, 64'd0);
            if (bus.cpu_q_tx_wr != '0) begin
                n_txwr++;
                checkOutput("tx_wr_guard", {bus.txfifo_rd_en, |(bus.cpu_q_tx_wr & bus.cpu_q_tx_full)}, 64'b10);
                checkOutput("tx_data_is_head", bus.cpu_q_tx_data, bus.txfifo_rd_data[34:0]);
                if (exp_tx.size() == 0) begin
                    checkOutput("tx_unexpected_wr", bus.cpu_q_tx_wr, 64'd0);
                end else begin
                    et = exp_tx.pop_front();
                    oh = '0;
                    oh[et[36:35]] = 1'b1;
                    checkOutput("tx_wr_qid", bus.cpu_q_tx_wr, oh);
                    checkOutput("tx_data", bus.cpu_q_tx_data, et[34:0]);
                    if (et[34]) mdl_tx++;
                end
            end else begin
                checkOutput("tx_data_quiet", bus.cpu_q_tx_data, 64'd0);
            end
            if (bus.rxfifo_wr) begin
                n_rxwr++;
                checkOutput("rxfifo_overflow", bus.rxfifo_full, 64'd0);
                if (exp_rx.size() == 0) begin
                    checkOutput("rx_unexpected_wr", bus.rxfifo_wr, 64'd0);
                end else begin
                    er = exp_rx.pop_front();
                    checkOutput("rx_data", bus.rxfifo_wr_data, er[34:0]);
                    oh = '0;
                    if (!er[39]) oh[er[36:35]] = 1'b1;
                    checkOutput("rx_rd_en", bus.cpu_q_rx_rd_en, oh);
                    if (!er[39]) checkOutput("rx_q_underflow", |(bus.cpu_q_rx_rd_en & bus.cpu_q_rx_empty), 64'd0);
                    if (!er[39] && er[34]) mdl_rx++;
                end
            end else begin
                checkOutput("rx_quiet", {bus.cpu_q_rx_rd_en, bus.rxfifo_wr_data}, 64'd0);
            end
        end
    end

    // Watchdog so a hung run still terminates
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence
    initial begin
        int b0;
        int b1;
        cpci_reset_n = 1'b0;
        updateInputs();
        applyStimulus(2);
        checkOutput("rst_tx_cnt", bus.tx_pkt_cnt, 64'd0);
        checkOutput("rst_rx_cnt", bus.rx_pkt_cnt, 64'd0);
        cpci_reset_n = 1'b1;
        applyStimulus(1);

        $display("[TB] tx packet to queue 2");
        b0 = n_txwr;
        addTx(req(1'b0, 4'd2), -1);
        addTx(dw(1'b0, 2'b00, 32'hA1A1_0001), 2);
        addTx(dw(1'b0, 2'b00, 32'hA1A1_0002), 2);
        addTx(dw(1'b1, 2'b10, 32'hA1A1_0003), 2);
        runUntilDone("s1", 30);
        checkOutput("s1_tx_pkt_cnt", bus.tx_pkt_cnt, 64'd1);
        checkOutput("s1_writes", 64'(n_txwr - b0), 64'd3);
        checkOutput("s1_no_errors", 64'(n_bad_qid + n_proto), 64'd0);

        $display("[TB] tx packet to queue 1 with toggling full");
        b0 = n_txwr;
        addTx(req(1'b0, 4'd1), -1);
        for (int i = 0; i < 5; i++) addTx(dw(i == 4, 2'b00, 32'hB0B0_0000 + 32'(i)), 1);
        b1 = 0;
        while (!allDone() && b1 < 60) begin
            tx_full_v[1] = ~tx_full_v[1];
            applyStimulus(1);
            b1++;
        end
        checkOutput("s2_done", 64'(allDone()), 64'd1);
        tx_full_v = '0;
        applyStimulus(2);
        checkOutput("s2_tx_pkt_cnt", bus.tx_pkt_cnt, 64'd2);
        checkOutput("s2_writes", 64'(n_txwr - b0), 64'd5);

        $display("[TB] rx packet from queue 3 with rx FIFO stall");
        b0 = n_rxwr;
        addRx(3, {1'b0, 2'b00, 32'hC3C3_0001});
        addRx(3, {1'b0, 2'b00, 32'hC3C3_0002});
        addRx(3, {1'b1, 2'b11, 32'hC3C3_0003});
        addTx(req(1'b1, 4'd3), -1);
        applyStimulus(2);
        rx_full_v = 1'b1;
        applyStimulus(2);
        rx_full_v = 1'b0;
        runUntilDone("s3", 30);
        checkOutput("s3_rx_pkt_cnt", bus.rx_pkt_cnt, 64'd1);
        checkOutput("s3_writes", 64'(n_rxwr - b0), 64'd3);

        $display("[TB] bad qid tx drop and rx filler");
        b0 = n_bad_qid;
        b1 = n_txwr;
        addTx(req(1'b0, 4'd7), -1);
        addTx(dw(1'b0, 2'b00, 32'hDEAD_0001), -1);
        addTx(dw(1'b1, 2'b01, 32'hDEAD_0002), -1);
        addTx(req(1'b1, 4'd9), -1);
        addFiller();
        rx_full_v = 1'b1;
        applyStimulus(6);
        checkOutput("s4_filler_waits", 64'(exp_rx.size()), 64'd1);
        rx_full_v = 1'b0;
        runUntilDone("s4", 30);
        checkOutput("s4_bad_qid_pulses", 64'(n_bad_qid - b0), 64'd2);
        checkOutput("s4_no_tx_wr", 64'(n_txwr - b1), 64'd0);
        checkOutput("s4_rx_pkt_cnt", bus.rx_pkt_cnt, 64'd1);

        $display("[TB] truncated tx packet followed by rx request");
        b0 = n_proto;
        addTx(req(1'b0, 4'd0), -1);
        addTx(dw(1'b0, 2'b00, 32'hD0D0_0001), 0);
        addTx(req(1'b1, 4'd0), -1);
        addRx(0, {1'b1, 2'b10, 32'hE0E0_0001});
        runUntilDone("s5", 30);
        checkOutput("s5_proto_pulses", 64'(n_proto - b0), 64'd1);
        checkOutput("s5_rx_pkt_cnt", bus.rx_pkt_cnt, 64'd2);
        checkOutput("s5_tx_pkt_cnt", bus.tx_pkt_cnt, 64'd2);

        $display("[TB] reset in the middle of a tx packet");
        addTx(req(1'b0, 4'd2), -1);
        addTx(dw(1'b0, 2'b00, 32'hF1F1_0001), 2);
        addTx(dw(1'b0, 2'b00, 32'hF1F1_0002), 2);
        addTx(dw(1'b0, 2'b00, 32'hF1F1_0003), 2);
        addTx(dw(1'b1, 2'b00, 32'hF1F1_0004), 2);
        applyStimulus(2);
        #2;
        cpci_reset_n = 1'b0;
        #1;
        checkOutput("s6_async_strobes",
            {bus.txfifo_rd_en, bus.cpu_q_tx_wr, bus.cpu_q_rx_rd_en, bus.rxfifo_wr}, 64'd0);
        checkOutput("s6_async_tx_cnt", bus.tx_pkt_cnt, 64'd0);
        checkOutput("s6_async_tx_data", bus.cpu_q_tx_data, 64'd0);
        exp_tx.delete();
        applyStimulus(2);
        cpci_reset_n = 1'b1;
        b0 = n_proto;
        runUntilDone("s6_leftover", 30);
        checkOutput("s6_leftover_pulses", 64'(n_proto - b0), 64'd3);
        addTx(req(1'b0, 4'd3), -1);
        addTx(dw(1'b1, 2'b00, 32'hF3F3_0001), 3);
        runUntilDone("s6_after", 30);
        checkOutput("s6_tx_pkt_cnt", bus.tx_pkt_cnt, 64'd1);
        checkOutput("s6_rx_pkt_cnt", bus.rx_pkt_cnt, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
